axi4lite_slave_mem: RTL
=======================

// Module: axi4lite_slave_mem
// PURPOSE
// - AXI4-Lite slave SRAM. Responder end of the memory bus driven by rv32i_cpu_top's m_axi_* master.
// - Serves instruction fetches and load/store traffic in simulation and FPGA builds.
// - Independent read and write channels. One outstanding transaction per direction.
// - Byte-lane write strobes. Registered responses.
// PARAMETERS
// - ADDR_WIDTH   32      AXI address width
// - DATA_WIDTH   32      data width; fixed at 32 (4 byte lanes)
// - DEPTH_WORDS  4096    memory depth in 32-bit words; power of two
// - BASE_ADDR    32'h0   byte address mapped to word 0
// PORTS
// - clk            in   1          clock
// - rst_n          in   1          asynchronous, active-low reset
// - s_axi_awaddr   in   ADDR_WIDTH write address
// - s_axi_awvalid  in   1          write address valid
// - s_axi_awready  out  1          write address ready
// - s_axi_wdata    in   32         write data
// - s_axi_wstrb    in   4          byte-lane write enables
// - s_axi_wvalid   in   1          write data valid
// - s_axi_wready   out  1          write data ready
// - s_axi_bresp    out  2          write response (OKAY=2'b00, SLVERR=2'b10)
// - s_axi_bvalid   out  1          write response valid
// - s_axi_bready   in   1          write response ready
// - s_axi_araddr   in   ADDR_WIDTH read address
// - s_axi_arvalid  in   1          read address valid
// - s_axi_arready  out  1          read address ready
// - s_axi_rdata    out  32         read data
// - s_axi_rresp    out  2          read response
// - s_axi_rvalid   out  1          read data valid
// - s_axi_rready   in   1          read data ready
// BEHAVIOUR
// - Reset values:
//   - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
//   - Both FSMs in IDLE, so awready=wready=arready=1.
//   - Memory contents are not reset.
// - Address decode: word index = (addr - BASE_ADDR) >> 2. addr[1:0] ignored. No unaligned support.
// - Write FSM states:
//   - W_IDLE: awready=1, wready=1.
//     - AW and W both handshake -> W_RESP.
//     - AW only -> W_DATA (latch address).
//     - W only -> W_ADDR (latch data and strobe).
//   - W_DATA: awready=0, wready=1. W handshake -> W_RESP.
//   - W_ADDR: awready=1, wready=0. AW handshake -> W_RESP.
//   - W_RESP: awready=0, wready=0, bvalid=1. bready -> W_IDLE.
// - Memory write happens on the clock edge that completes the AW+W pair.
// - bvalid rises the following cycle (1-cycle latency). bresp is held stable until bready.
// - wstrb[i] enables byte i. wstrb=4'h0 leaves memory unchanged and returns OKAY.
// - Read FSM states:
//   - R_IDLE: arready=1. AR handshake -> R_DATA; memory word registered into rdata at the same edge.
//   - R_DATA: arready=0, rvalid=1. rdata/rresp held stable until rready -> R_IDLE.
// - Read latency: rvalid one cycle after AR handshake.
// - A new AR is accepted no earlier than the cycle after the R handshake (no bubble-free back-to-back).
// - Read and write channels are fully independent. Both may complete on the same edge.
// - Same-edge read and write to the same word: read returns the old data (read-before-write).
// - rst_n asserted mid-transaction:
//   - Pending B/R responses are dropped; FSMs return to IDLE.
//   - Latched AW/W halves are discarded; memory keeps its contents.
// CONFIGURATION
// - AXIMEM_ERR_EN defined:
//   - An address outside [BASE_ADDR, BASE_ADDR + DEPTH_WORDS*4) returns SLVERR (2'b10).
//   - Out-of-range writes leave memory unmodified.
//   - Out-of-range reads return rdata=32'h0.
// - AXIMEM_ERR_EN undefined:
//   - Index is taken modulo DEPTH_WORDS (wraps).
//   - Responses are always OKAY.
// TESTING
// - Write 32'hDEADBEEF @0x10, wstrb=4'hF, AW+W same cycle -> bvalid next cycle, bresp=00. Read 0x10 -> rdata=DEADBEEF, rresp=00.
// - W valid 3 cycles before AW -> wready=0 after W capture, awready=1. Exactly one B after AW. Readback correct.
// - Word @0x20 = 32'h11223344; write 32'h0000AB00 wstrb=4'h2 -> read 0x20 returns 32'h1122AB44.
// - Hold rready=0 for 5 cycles after AR -> rvalid/rdata stable, arready=0. Second AR accepted only after R handshake.
// - Address BASE_ADDR+DEPTH_WORDS*4:
//   - With AXIMEM_ERR_EN: bresp=rresp=10, rdata=0, word 0 unchanged.
//   - Without: the write lands in word 0.
// - Same-cycle AR and AW+W to 0x40 (old 32'h1, new 32'h2) -> R returns 32'h1. Next read returns 32'h2.
// - rst_n pulse while in W_RESP -> bvalid=0 immediately. awready=wready=1 after release.

Source files
------------

// File: rtl/axi4lite_slave_mem.sv
// -----------------------------------------------------------------------------
// axi4lite_slave_mem
//
// AXI4-Lite slave SRAM. It sits on the responder end of the memory bus driven
// by the CPU's m_axi_* master. The read and write channels are independent,
// with one outstanding transaction per direction. Writes use byte-lane
// strobes, and responses are registered.
//
// Ports
//   clk, rst_n              clock; asynchronous active-low reset
//   s_axi_aw*               write address channel (awaddr, awvalid, awready)
//   s_axi_w*                write data channel (wdata, wstrb, wvalid, wready)
//   s_axi_b*                write response channel (bresp, bvalid, bready)
//   s_axi_ar*               read address channel (araddr, arvalid, arready)
//   s_axi_r*                read data channel (rdata, rresp, rvalid, rready)
//
// Configuration
//   AXIMEM_ERR_EN  When this macro is defined, addresses outside
//                  [BASE_ADDR, BASE_ADDR + DEPTH_WORDS*4) return SLVERR.
//                  Those writes are dropped and those reads return zero.
//                  When it is undefined, the word index wraps modulo
//                  DEPTH_WORDS and every response is OKAY.
// -----------------------------------------------------------------------------
module axi4lite_slave_mem #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int                  IDX_W  = $clog2(DEPTH_WORDS);
  localparam int                  STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] SPAN   = (ADDR_WIDTH+1)'(64'(DEPTH_WORDS) * 64'd4);
  localparam logic [1:0]          OKAY   = 2'b00;
  localparam logic [1:0]          SLVERR = 2'b10;

`ifdef AXIMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_ADDR, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}                 r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  logic                  wr_fire;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_off, rd_off;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic                  wr_ok, rd_ok, ar_fire;
  logic [IDX_W-1:0]      wr_idx, rd_idx;

  // When one half of the pair was captured earlier, use the latched copy of
  // that half. Otherwise take the value straight from the bus.
  assign wr_addr = (w_state == W_DATA) ? aw_addr_q : s_axi_awaddr;
  assign wr_data = (w_state == W_ADDR) ? w_data_q  : s_axi_wdata;
  assign wr_strb = (w_state == W_ADDR) ? w_strb_q  : s_axi_wstrb;

  // An address below BASE_ADDR wraps to a large offset, so the single
  // unsigned compare also rejects it.
  assign wr_off = wr_addr - BASE_ADDR;
  assign rd_off = s_axi_araddr - BASE_ADDR;
  assign wr_idx = wr_off[IDX_W+1:2];
  assign rd_idx = rd_off[IDX_W+1:2];
  assign wr_ok  = !ERR_EN || ({1'b0, wr_off} < SPAN);
  assign rd_ok  = !ERR_EN || ({1'b0, rd_off} < SPAN);

  // ---------------------------------------------------------------- write FSM
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and simulation order cannot matter.
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case
    // can leave a signal unassigned and infer a latch.
    w_next        = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    wr_fire       = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        s_axi_wready  = 1'b1;
        if (s_axi_awvalid && s_axi_wvalid) begin
          w_next  = W_RESP;
          wr_fire = 1'b1;
        end else if (s_axi_awvalid) begin
          w_next = W_DATA;
        end else if (s_axi_wvalid) begin
          w_next = W_ADDR;
        end
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          w_next  = W_RESP;
          wr_fire = 1'b1;
        end
      end
      W_ADDR: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) begin
          w_next  = W_RESP;
          wr_fire = 1'b1;
        end
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Capture a lone half. A state reset makes the old contents irrelevant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      s_axi_bresp <= OKAY;
    end else begin
      if (w_state == W_IDLE && s_axi_awvalid) aw_addr_q <= s_axi_awaddr;
      if (w_state == W_IDLE && s_axi_wvalid) begin
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (wr_fire) s_axi_bresp <= wr_ok ? OKAY : SLVERR;
    end
  end

  // NOTE: the storage array has no reset. Contents survive rst_n, and the
  // array can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_fire && wr_ok) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read FSM
  assign ar_fire = (r_state == R_IDLE) && s_axi_arvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next        = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // This samples the array on the same edge as any write, so a same-edge
  // read of the written word returns the old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_rdata <= '0;
      s_axi_rresp <= OKAY;
    end else if (ar_fire) begin
      s_axi_rdata <= rd_ok ? mem[rd_idx] : '0;
      s_axi_rresp <= rd_ok ? OKAY : SLVERR;
    end
  end

endmodule
